// File: rtl/ketchup_padder.sv
// ketchup_padder: SHA-3 input stage. Packs 32-bit message words into one
// RATE_BITS block, applies SHA-3 padding (0x06 ... 0x80) and hands the block
// to the Keccak permutation over a valid/ready handshake.
// Optional build macro KETCHUP_PADDER_OVERRUN_EN adds a sticky overrun flag
// for words presented while the buffer is not accepting.
//
// state  | meaning
// ACCEPT | taking message words at idx
// PAD    | message ended, writing padding words up to the end of the block
// FULL   | block_out complete, waiting for block_ready
// DONE   | final block handed off, inputs ignored until clear/reset
module ketchup_padder #(
  parameter int RATE_BITS = 1152
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 clear,
  input  logic [31:0]          in,
  input  logic                 in_ready,
  input  logic                 is_last,
  input  logic [1:0]           byte_num,
  output logic                 buffer_full,
  output logic [RATE_BITS-1:0] block_out,
  output logic                 block_valid,
  output logic                 block_last,
  input  logic                 block_ready
`ifdef KETCHUP_PADDER_OVERRUN_EN
  ,
  output logic                 overrun
`endif
);

  localparam int WORDS = RATE_BITS / 32;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {ACCEPT, PAD, FULL, DONE} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  // Ascending packed range puts word 0 in the most significant bits.
  logic [0:WORDS-1][31:0]  blk;

  assign block_out = blk;

  // Keep the first n message bytes, then the 0x06 domain/pad byte, then zeros.
  function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [1:0] n);
    case (n)
      2'd0:    return 32'h0600_0000;
      2'd1:    return {w[31:24], 24'h06_0000};
      2'd2:    return {w[31:16], 16'h0600};
      default: return {w[31:8], 8'h06};
    endcase
  endfunction

  // Padder FSM: word assembly, padding and block handoff with registered outputs.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state       <= ACCEPT;
      idx         <= '0;
      blk         <= '0;
      block_valid <= 1'b0;
      block_last  <= 1'b0;
      buffer_full <= 1'b0;
    end else if (clear) begin
      state       <= ACCEPT;
      idx         <= '0;
      blk         <= '0;
      block_valid <= 1'b0;
      block_last  <= 1'b0;
      buffer_full <= 1'b0;
    end else begin
      case (state)
        ACCEPT: begin
          if (in_ready) begin
            if (!is_last) begin
              blk[idx] <= in;
              if (idx == LAST_IDX) begin
                state       <= FULL;
                block_valid <= 1'b1;
                block_last  <= 1'b0;
                buffer_full <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else if (idx == LAST_IDX) begin
              // Last word lands in the final slot: both pad bytes share this word.
              blk[idx]    <= pad_word(in, byte_num) | 32'h0000_0080;
              state       <= FULL;
              block_valid <= 1'b1;
              block_last  <= 1'b1;
              buffer_full <= 1'b1;
            end else begin
              blk[idx]    <= pad_word(in, byte_num);
              idx         <= idx + 1'b1;
              state       <= PAD;
              buffer_full <= 1'b1;
            end
          end
        end
        PAD: begin
          if (idx == LAST_IDX) begin
            blk[idx]    <= 32'h0000_0080;
            state       <= FULL;
            block_valid <= 1'b1;
            block_last  <= 1'b1;
          end else begin
            blk[idx] <= 32'h0000_0000;
            idx      <= idx + 1'b1;
          end
        end
        FULL: begin
          if (block_ready) begin
            block_valid <= 1'b0;
            block_last  <= 1'b0;
            if (block_last) begin
              state <= DONE;
            end else begin
              state       <= ACCEPT;
              idx         <= '0;
              buffer_full <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= ACCEPT;
        end
      endcase
    end
  end

`ifdef KETCHUP_PADDER_OVERRUN_EN
  // Sticky flag for any word offered while the buffer is not accepting.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      overrun <= 1'b0;
    end else if (clear) begin
      overrun <= 1'b0;
    end else if (in_ready && buffer_full) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ketchup_padder.sv
// Bench for ketchup_padder: random messages are padded by a byte-level SHA-3
// padding model and compared block by block against the DUT.
module tb_ketchup_padder;

  localparam int RATE_BITS = 1152;
  localparam int WORDS     = RATE_BITS / 32;
  localparam int BYTES     = RATE_BITS / 8;

  logic                 aclk;
  logic                 aresetn;
  logic                 clear;
  logic [31:0]          in_word;
  logic                 in_ready;
  logic                 is_last;
  logic [1:0]           byte_num;
  logic                 buffer_full;
  logic [RATE_BITS-1:0] block_out;
  logic                 block_valid;
  logic                 block_last;
  logic                 block_ready;
`ifdef KETCHUP_PADDER_OVERRUN_EN
  logic                 overrun;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0]  msg[$];
  logic [7:0]  pq[$];
  logic [31:0] exp_blk[WORDS];

  ketchup_padder #(.RATE_BITS(RATE_BITS)) dut (
    .S_AXI_ACLK    (aclk),
    .S_AXI_ARESETN (aresetn),
    .clear         (clear),
    .in            (in_word),
    .in_ready      (in_ready),
    .is_last       (is_last),
    .byte_num      (byte_num),
    .buffer_full   (buffer_full),
    .block_out     (block_out),
    .block_valid   (block_valid),
    .block_last    (block_last),
    .block_ready   (block_ready)
`ifdef KETCHUP_PADDER_OVERRUN_EN
    ,
    .overrun       (overrun)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Byte-level SHA-3 padding of the whole message: 0x06, zeros to the rate, 0x80 OR'd into the last byte.
  function automatic void build_model();
    pq = msg;
    pq.push_back(8'h06);
    while (pq.size() % BYTES != 0) pq.push_back(8'h00);
    pq[pq.size()-1] = pq[pq.size()-1] | 8'h80;
  endfunction

  function automatic void load_block(input int b);
    for (int w = 0; w < WORDS; w++) begin
      exp_blk[w] = {pq[b*BYTES+4*w], pq[b*BYTES+4*w+1], pq[b*BYTES+4*w+2], pq[b*BYTES+4*w+3]};
    end
  endfunction

  // Called at a negedge; presents one word for exactly one rising edge.
  task automatic put_word(input logic [31:0] w, input logic last, input logic [1:0] bn);
    in_word  = w;
    is_last  = last;
    byte_num = bn;
    in_ready = 1'b1;
    @(negedge aclk);
    in_ready = 1'b0;
    is_last  = 1'b0;
    in_word  = $urandom;
    byte_num = 2'($urandom);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge aclk);
    clear = 1'b0;
  endtask

  task automatic take_block(input bit exp_last, input int exp_lat, input int hold);
    int lat;
    int bad_w;
    logic [RATE_BITS-1:0] snap;
    lat = 1;
    while (!block_valid && lat < 100) begin
      @(negedge aclk);
      lat++;
    end
    total++;
    if (block_valid !== 1'b1) begin
      bad++;
      $display("FAIL block_valid_timeout: block_valid=%b after %0d cycles, required 1", block_valid, lat);
      return;
    end
    if (exp_lat > 0) begin
      total++;
      if (lat !== exp_lat) begin
        bad++;
        $display("FAIL latency: got %0d cycles, required %0d", lat, exp_lat);
      end
    end
    bad_w = -1;
    for (int w = 0; w < WORDS; w++) begin
      if (bad_w < 0 && block_out[RATE_BITS-1-32*w -: 32] !== exp_blk[w]) bad_w = w;
    end
    total++;
    if (bad_w >= 0) begin
      bad++;
      $display("FAIL block_word[%0d]: got %h, required %h", bad_w,
               block_out[RATE_BITS-1-32*bad_w -: 32], exp_blk[bad_w]);
    end
    total++;
    if (block_last !== exp_last || buffer_full !== 1'b1) begin
      bad++;
      $display("FAIL full_flags: block_last=%b buffer_full=%b, required %b 1", block_last, buffer_full, exp_last);
    end
    snap = block_out;
    for (int h = 0; h < hold; h++) begin
      put_word($urandom, 1'($urandom), 2'($urandom));
      total++;
      if (block_valid !== 1'b1 || block_out !== snap || block_last !== exp_last) begin
        bad++;
        $display("FAIL hold_stable: cycle %0d valid=%b last=%b changed=%b, required 1 %b 0",
                 h, block_valid, block_last, block_out !== snap, exp_last);
      end
    end
    block_ready = 1'b1;
    @(negedge aclk);
    block_ready = 1'b0;
    total++;
    if (block_valid !== 1'b0 || buffer_full !== exp_last) begin
      bad++;
      $display("FAIL handoff: block_valid=%b buffer_full=%b, required 0 %b", block_valid, buffer_full, exp_last);
    end
  endtask

  // Sends msg as full words plus one is_last word, checks every block, then the idle state and clear.
  task automatic send_msg(input int hold);
    int n;
    int nfull;
    int nblk;
    int r;
    int idx_last;
    logic [31:0] w;
    n     = msg.size();
    nfull = n / 4;
    r     = n % 4;
    build_model();
    nblk = pq.size() / BYTES;
    for (int j = 0; j < nfull; j++) begin
      put_word({msg[4*j], msg[4*j+1], msg[4*j+2], msg[4*j+3]}, 1'b0, 2'd0);
      if ((j + 1) % WORDS == 0) begin
        load_block((j + 1) / WORDS - 1);
        take_block(1'b0, 1, hold);
      end
    end
    w = $urandom;
    for (int k = 0; k < r; k++) w[31-8*k -: 8] = msg[4*nfull+k];
    idx_last = nfull % WORDS;
    put_word(w, 1'b1, 2'(r));
    load_block(nblk - 1);
    take_block(1'b1, WORDS - idx_last, hold);
    total++;
    if (buffer_full !== 1'b1 || block_valid !== 1'b0) begin
      bad++;
      $display("FAIL done_state: buffer_full=%b block_valid=%b, required 1 0", buffer_full, block_valid);
    end
    put_word($urandom, 1'b1, 2'd0);
    repeat (3) @(negedge aclk);
    total++;
    if (buffer_full !== 1'b1 || block_valid !== 1'b0) begin
      bad++;
      $display("FAIL done_ignores: buffer_full=%b block_valid=%b, required 1 0", buffer_full, block_valid);
    end
    pulse_clear();
    total++;
    if (buffer_full !== 1'b0 || block_valid !== 1'b0 || block_out !== '0) begin
      bad++;
      $display("FAIL clear_from_done: buffer_full=%b block_valid=%b block_out_zero=%b, required 0 0 1",
               buffer_full, block_valid, block_out === '0);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    clear = 1'b0; in_word = '0; in_ready = 1'b0; is_last = 1'b0; byte_num = '0; block_ready = 1'b0;
    repeat (3) @(negedge aclk);
    total++;
    if (buffer_full !== 1'b0 || block_valid !== 1'b0 || block_last !== 1'b0 || block_out !== '0) begin
      bad++;
      $display("FAIL reset: buffer_full=%b block_valid=%b block_last=%b block_out_zero=%b, required 0 0 0 1",
               buffer_full, block_valid, block_last, block_out === '0);
    end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_empty();
    msg.delete();
    send_msg(0);
  endtask

  task automatic test_abc();
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    send_msg(1);
  endtask

  task automatic test_last_in_final_slot();
    msg.delete();
    for (int i = 0; i < 35 * 4 + 3; i++) msg.push_back(8'($urandom));
    send_msg(0);
  endtask

  task automatic test_block_boundary();
    msg.delete();
    for (int i = 0; i < BYTES; i++) msg.push_back(8'($urandom));
    send_msg(5);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int len;
      len = $urandom_range(0, 400);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      send_msg($urandom_range(0, 3));
    end
  endtask

  task automatic test_clear_mid_pad();
    put_word($urandom, 1'b1, 2'd0);
    repeat (8) @(negedge aclk);
    total++;
    if (buffer_full !== 1'b1 || block_valid !== 1'b0) begin
      bad++;
      $display("FAIL in_pad: buffer_full=%b block_valid=%b, required 1 0", buffer_full, block_valid);
    end
    pulse_clear();
    total++;
    if (buffer_full !== 1'b0 || block_valid !== 1'b0 || block_last !== 1'b0 || block_out !== '0) begin
      bad++;
      $display("FAIL clear_mid_pad: buffer_full=%b block_valid=%b block_last=%b block_out_zero=%b, required 0 0 0 1",
               buffer_full, block_valid, block_last, block_out === '0);
    end
    msg.delete();
    for (int i = 0; i < 9; i++) msg.push_back(8'($urandom));
    send_msg(0);
  endtask

  task automatic test_reset_mid_full();
    for (int j = 0; j < WORDS; j++) put_word($urandom, 1'b0, 2'd0);
    total++;
    if (block_valid !== 1'b1 || block_last !== 1'b0 || buffer_full !== 1'b1) begin
      bad++;
      $display("FAIL full_before_reset: valid=%b last=%b buffer_full=%b, required 1 0 1",
               block_valid, block_last, buffer_full);
    end
    #2 aresetn = 1'b0;
    #1;
    total++;
    if (buffer_full !== 1'b0 || block_valid !== 1'b0 || block_last !== 1'b0 || block_out !== '0) begin
      bad++;
      $display("FAIL reset_mid_full: buffer_full=%b block_valid=%b block_last=%b block_out_zero=%b, required 0 0 0 1",
               buffer_full, block_valid, block_last, block_out === '0);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    msg.delete();
    for (int i = 0; i < 22; i++) msg.push_back(8'($urandom));
    send_msg(0);
  endtask

`ifdef KETCHUP_PADDER_OVERRUN_EN
  task automatic test_overrun();
    pulse_clear();
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear0: got %b, required 0", overrun);
    end
    for (int j = 0; j < WORDS; j++) put_word($urandom, 1'b0, 2'd0);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_idle: got %b, required 0", overrun);
    end
    put_word($urandom, 1'b0, 2'd0);
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set: got %b, required 1", overrun);
    end
    block_ready = 1'b1;
    @(negedge aclk);
    block_ready = 1'b0;
    total++;
    if (overrun !== 1'b1 || buffer_full !== 1'b0) begin
      bad++;
      $display("FAIL overrun_sticky: overrun=%b buffer_full=%b, required 1 0", overrun, buffer_full);
    end
    pulse_clear();
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_cleared: got %b, required 0", overrun);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_last_in_final_slot();
    test_block_boundary();
    test_random();
    test_clear_mid_pad();
    test_reset_mid_full();
`ifdef KETCHUP_PADDER_OVERRUN_EN
    test_overrun();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
